// File: rtl/lz_pkg.sv
// rtl/lz_pkg.sv - shared types and constants for the leading-zero word feeder
// Purpose: serializer state encoding, default geometry, the clog2 helper
//          and the largest operand width the downstream 9-bit count can hold.
// Ports:   none (package).
package lz_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } lz_state_e;

  localparam int LZ_WIDTH_DEFAULT = 8;
  localparam int LZ_WORD_DEFAULT  = 4;
  localparam int LZ_DEPTH_DEFAULT = 2;

  // Largest leading-zero count the downstream counter can report.
  localparam int LZ_MAX_COUNT = 511;

  function automatic int lz_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lz_op_fifo.sv
// rtl/lz_op_fifo.sv - register FIFO holding whole {mode, operand} entries
// Purpose: DEPTH-entry operand buffer between the producer handshake and
//          the serializer; pointers wrap modulo DEPTH (any DEPTH, not only
//          powers of two).
// Ports:   clk, rst         clock and synchronous active-high reset
//          i_push/i_push_data  write request and entry (ignored when full)
//          i_pop            drop head entry (ignored when empty)
//          o_head           current head entry
//          o_full/o_empty   occupancy flags
//          o_count          number of stored entries
module lz_op_fifo
  import lz_pkg::*;
#(
  parameter  int DW    = 33,
  parameter  int DEPTH = 2,
  localparam int CNT_W = lz_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [DW-1:0]    i_push_data,
  input  logic             i_pop,
  output logic [DW-1:0]    o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (lz_clog2(DEPTH) < 1) ? 1 : lz_clog2(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lz_word_feeder.sv
// rtl/lz_word_feeder.sv - operand buffer and MSB-word-first serializer for the leading-zero counter
// Purpose: accepts WIDTH*WORD-bit operands over valid/ready, queues them,
//          and streams each one word per cycle toward the counter. In turbo
//          mode the operand ends at its first nonzero word.
// Ports:   CLK, rst         clock and synchronous active-high reset
//          in_valid/in_ready/in_data/in_mode  operand handshake
//          ivalid/mode/data word stream toward the counter
//          busy             FIFO non-empty or serializer sending
//          ops_done         wrapping count of fully emitted operands
module lz_word_feeder
  import lz_pkg::*;
#(
  parameter int WIDTH = LZ_WIDTH_DEFAULT,
  parameter int WORD  = LZ_WORD_DEFAULT,
  parameter int DEPTH = LZ_DEPTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH*WORD-1:0] in_data,
  input  logic                  in_mode,
  output logic                  ivalid,
  output logic                  mode,
  output logic [WIDTH-1:0]      data,
  output logic                  busy,
  output logic [15:0]           ops_done
);

  localparam int OPW   = WIDTH * WORD;
  localparam int IDX_W = (lz_clog2(WORD) < 1) ? 1 : lz_clog2(WORD);
  localparam int CNT_W = lz_clog2(DEPTH + 1);

  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16) || WORD < 1 || WORD > 255 ||
      DEPTH < 1 || DEPTH > 8 || OPW > LZ_MAX_COUNT) begin : g_param_check
    $error("lz_word_feeder: illegal WIDTH/WORD/DEPTH combination");
  end

  lz_state_e        r_state;
  logic [OPW-1:0]   r_shift;
  logic [IDX_W-1:0] r_idx;
  logic             r_mode;
  logic             r_ivalid;
  logic [15:0]      r_ops_done;

  logic             w_push;
  logic             w_pop;
  logic [OPW:0]     w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_fifo_count;
  logic [WIDTH-1:0] w_cur_word;
  logic             w_last;

  // in_ready depends only on the registered occupancy.
  assign in_ready = (w_fifo_count < CNT_W'(DEPTH));
  assign w_push   = in_valid && !w_fifo_full;

  // The shift register is cleared whenever the serializer goes idle, so the
  // top word doubles as the data output and reads 0 outside SEND.
  assign w_cur_word = r_shift[OPW-1 -: WIDTH];
  assign w_last     = (r_idx == IDX_W'(WORD - 1)) || (r_mode && (w_cur_word != '0));
  assign w_pop      = !w_fifo_empty && ((r_state == IDLE) || w_last);

  lz_op_fifo #(
    .DW    (OPW + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (CLK),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({in_mode, in_data}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_idx      <= '0;
      r_mode     <= 1'b0;
      r_ivalid   <= 1'b0;
      r_ops_done <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            r_state  <= SEND;
            r_shift  <= w_head[OPW-1:0];
            r_mode   <= w_head[OPW];
            r_idx    <= '0;
            r_ivalid <= 1'b1;
          end
        end
        SEND: begin
          if (w_last) begin
            r_ops_done <= r_ops_done + 16'd1;
            if (!w_fifo_empty) begin
              // Reload in the same edge so back-to-back operands leave no gap.
              r_shift  <= w_head[OPW-1:0];
              r_mode   <= w_head[OPW];
              r_idx    <= '0;
              r_ivalid <= 1'b1;
            end else begin
              r_state  <= IDLE;
              r_shift  <= '0;
              r_mode   <= 1'b0;
              r_idx    <= '0;
              r_ivalid <= 1'b0;
            end
          end else begin
            r_shift <= r_shift << WIDTH;
            r_idx   <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_shift  <= '0;
          r_mode   <= 1'b0;
          r_idx    <= '0;
          r_ivalid <= 1'b0;
        end
      endcase
    end
  end

  assign ivalid   = r_ivalid;
  assign mode     = r_mode;
  assign data     = w_cur_word;
  assign busy     = !w_fifo_empty || (r_state == SEND);
  assign ops_done = r_ops_done;

endmodule
